// File: rtl/ecc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : ecc_pkg
// Purpose  : Shared constants and enumerations for the ECC operand I/O path.
// Revision : 1.0 - initial release
// ============================================================================
package ecc_pkg;

    localparam int c_digit_w = 4;
    localparam int c_word_w  = 32;
    localparam int c_n_ch    = 5;

    typedef enum logic [2:0] {
        CH_PRIME = 3'd0,
        CH_PX    = 3'd1,
        CH_PY    = 3'd2,
        CH_A     = 3'd3,
        CH_K     = 3'd4
    } ch_idx_t;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_HOLD = 2'd2
    } loader_state_t;

    typedef enum logic [0:0] {
        SER_IDLE = 1'b0,
        SER_RUN  = 1'b1
    } ser_state_t;

endpackage : ecc_pkg
`default_nettype wire

// File: rtl/digit_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : digit_serializer
// Purpose  : Emits a captured WORD_W-bit result as DIGIT_W-bit digits, MSD first.
// Revision : 1.0 - initial release
// ============================================================================
module digit_serializer
    import ecc_pkg::*;
#(
    parameter int DIGIT_W = c_digit_w,
    parameter int WORD_W  = c_word_w
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               res_load,
    input  logic [WORD_W-1:0]  res_word,
    output logic               res_busy,
    output logic               res_valid,
    output logic [DIGIT_W-1:0] res_digit,
    output logic               res_last
);

    localparam int c_ndig  = WORD_W / DIGIT_W;
    localparam int c_idx_w = $clog2(c_ndig + 1);

    ser_state_t         r_state_q, w_state_d;
    logic [c_idx_w-1:0] r_idx_q,   w_idx_d;
    logic [WORD_W-1:0]  r_sreg_q,  w_sreg_d;
    logic               r_valid_q, w_valid_d;
    logic [DIGIT_W-1:0] r_digit_q, w_digit_d;
    logic               r_last_q,  w_last_d;

    // The first digit is issued straight from res_word so it appears the cycle
    // after capture; the shift register then holds the remaining digits.
    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        w_sreg_d  = r_sreg_q;
        w_valid_d = 1'b0;
        w_digit_d = '0;
        w_last_d  = 1'b0;
        case (r_state_q)
            SER_IDLE: begin
                if (res_load) begin
                    w_state_d = SER_RUN;
                    w_idx_d   = c_idx_w'(1);
                    w_sreg_d  = res_word << DIGIT_W;
                    w_valid_d = 1'b1;
                    w_digit_d = res_word[WORD_W-1 -: DIGIT_W];
                    w_last_d  = (c_ndig == 1);
                end
            end
            SER_RUN: begin
                if (r_idx_q == c_idx_w'(c_ndig)) begin
                    w_state_d = SER_IDLE;
                    w_idx_d   = '0;
                end else begin
                    w_idx_d   = r_idx_q + 1'b1;
                    w_sreg_d  = r_sreg_q << DIGIT_W;
                    w_valid_d = 1'b1;
                    w_digit_d = r_sreg_q[WORD_W-1 -: DIGIT_W];
                    w_last_d  = (r_idx_q == c_idx_w'(c_ndig - 1));
                end
            end
            default: begin
                w_state_d = SER_IDLE;
                w_idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= SER_IDLE;
            r_idx_q   <= '0;
            r_sreg_q  <= '0;
            r_valid_q <= 1'b0;
            r_digit_q <= '0;
            r_last_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_sreg_q  <= w_sreg_d;
            r_valid_q <= w_valid_d;
            r_digit_q <= w_digit_d;
            r_last_q  <= w_last_d;
        end
    end

    assign res_busy  = (r_state_q == SER_RUN);
    assign res_valid = r_valid_q;
    assign res_digit = r_digit_q;
    assign res_last  = r_last_q;

endmodule : digit_serializer
`default_nettype wire

// File: rtl/ecc_operand_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ecc_operand_loader
// Purpose  : Assembles N_CH operand words from a digit bus with a valid/ready
//            handoff, and serialises the core result back onto a digit bus.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_operand_loader
    import ecc_pkg::*;
#(
    parameter int DIGIT_W = c_digit_w,
    parameter int WORD_W  = c_word_w,
    parameter int N_CH    = c_n_ch
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [N_CH*DIGIT_W-1:0]   in_digit,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_CH*WORD_W-1:0]    out_words,
    input  logic                      res_load,
    input  logic [WORD_W-1:0]         res_word,
    output logic                      res_busy,
    output logic                      res_valid,
    output logic [DIGIT_W-1:0]        res_digit,
    output logic                      res_last
);

    localparam int c_ndig  = WORD_W / DIGIT_W;
    localparam int c_cnt_w = $clog2(c_ndig + 1);

    loader_state_t              r_state_q,     w_state_d;
    logic [c_cnt_w-1:0]         r_cnt_q,       w_cnt_d;
    logic                       r_in_ready_q,  w_in_ready_d;
    logic                       r_out_valid_q, w_out_valid_d;
    logic [N_CH*WORD_W-1:0]     r_words_q,     w_words_d;
    logic                       w_beat;

    assign w_beat = in_valid && r_in_ready_q;

    // Words are never cleared between loads; NDIG beats overwrite every bit.
    always_comb begin
        w_words_d = r_words_q;
        if (w_beat) begin
            for (int c = 0; c < N_CH; c++) begin
                w_words_d[c*WORD_W +: WORD_W] = (r_words_q[c*WORD_W +: WORD_W] << DIGIT_W)
                                              | WORD_W'(in_digit[c*DIGIT_W +: DIGIT_W]);
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            LD_IDLE: begin
                if (w_beat) begin
                    if (c_ndig == 1) begin
                        w_state_d = LD_HOLD;
                        w_cnt_d   = '0;
                    end else begin
                        w_state_d = LD_LOAD;
                        w_cnt_d   = c_cnt_w'(1);
                    end
                end
            end
            LD_LOAD: begin
                if (w_beat) begin
                    if (r_cnt_q == c_cnt_w'(c_ndig - 1)) begin
                        w_state_d = LD_HOLD;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d   = r_cnt_q + 1'b1;
                    end
                end
            end
            LD_HOLD: begin
                if (out_ready) begin
                    w_state_d = LD_IDLE;
                end
            end
            default: begin
                w_state_d = LD_IDLE;
                w_cnt_d   = '0;
            end
        endcase
        // Handshake flags are registered from the next state so they line up
        // with r_state_q without any combinational path to the outputs.
        w_in_ready_d  = (w_state_d != LD_HOLD);
        w_out_valid_d = (w_state_d == LD_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= LD_IDLE;
            r_cnt_q       <= '0;
            r_in_ready_q  <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_words_q     <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
            r_words_q     <= w_words_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;
    assign out_words = r_words_q;

    digit_serializer #(
        .DIGIT_W (DIGIT_W),
        .WORD_W  (WORD_W)
    ) u_digit_serializer (
        .clk       (clk),
        .rst       (rst),
        .res_load  (res_load),
        .res_word  (res_word),
        .res_busy  (res_busy),
        .res_valid (res_valid),
        .res_digit (res_digit),
        .res_last  (res_last)
    );

endmodule : ecc_operand_loader
`default_nettype wire

// File: tb/tb_ecc_operand_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ecc_operand_loader
// Purpose  : Directed, table-driven bench for ecc_operand_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_operand_loader;
    import ecc_pkg::*;

    localparam int DW = 4;
    localparam int WW = 32;
    localparam int NC = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // default configuration
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [NC*DW-1:0] in_digit;
    logic [NC*WW-1:0] out_words;
    logic             res_load, res_busy, res_valid, res_last;
    logic [WW-1:0]    res_word;
    logic [DW-1:0]    res_digit;

    // DIGIT_W=8, WORD_W=16, N_CH=2
    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [15:0] in_digit2;
    logic [31:0] out_words2;
    logic        res_load2, res_busy2, res_valid2, res_last2;
    logic [15:0] res_word2;
    logic [7:0]  res_digit2;

    // DIGIT_W=4, WORD_W=4, N_CH=1 (NDIG=1)
    logic       in_valid3, in_ready3, out_valid3, out_ready3;
    logic [3:0] in_digit3, out_words3, res_word3, res_digit3;
    logic       res_load3, res_busy3, res_valid3, res_last3;

    ecc_operand_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_digit(in_digit), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_words(out_words),
        .res_load(res_load), .res_word(res_word), .res_busy(res_busy),
        .res_valid(res_valid), .res_digit(res_digit), .res_last(res_last)
    );

    ecc_operand_loader #(.DIGIT_W(8), .WORD_W(16), .N_CH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_digit(in_digit2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_words(out_words2),
        .res_load(res_load2), .res_word(res_word2), .res_busy(res_busy2),
        .res_valid(res_valid2), .res_digit(res_digit2), .res_last(res_last2)
    );

    ecc_operand_loader #(.DIGIT_W(4), .WORD_W(4), .N_CH(1)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_digit(in_digit3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_words(out_words3),
        .res_load(res_load3), .res_word(res_word3), .res_busy(res_busy3),
        .res_valid(res_valid3), .res_digit(res_digit3), .res_last(res_last3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] word_of(input int c);
        return out_words[c*WW +: WW];
    endfunction

    typedef struct {
        logic        vld;
        logic [3:0]  d0;
        logic [3:0]  d4;
        logic        ordy;
        logic        e_ird;
        logic        e_ov;
        logic [31:0] e_w0;
        logic [31:0] e_w4;
    } vec_t;

    vec_t vecs [21];

    task automatic reset_outputs_check(input string tag);
        chk({tag, " in_ready"},  in_ready,  1'b0);
        chk({tag, " out_valid"}, out_valid, 1'b0);
        for (int c = 0; c < NC; c++) chk($sformatf("%s word%0d", tag, c), word_of(c), 32'h0);
        chk({tag, " res_busy"},  res_busy,  1'b0);
        chk({tag, " res_valid"}, res_valid, 1'b0);
        chk({tag, " res_digit"}, res_digit, 4'h0);
        chk({tag, " res_last"},  res_last,  1'b0);
    endtask

    initial begin
        logic [31:0] sw;
        logic [3:0]  f0 [8];
        logic [3:0]  f4 [8];

        // Two loads: back-to-back, then the same digits with a 3-cycle gap.
        vecs[0]  = '{1'b1, 4'h1, 4'hF, 1'b0, 1'b1, 1'b0, 32'h00000001, 32'h0000000F};
        vecs[1]  = '{1'b1, 4'h2, 4'hE, 1'b0, 1'b1, 1'b0, 32'h00000012, 32'h000000FE};
        vecs[2]  = '{1'b1, 4'h3, 4'hD, 1'b0, 1'b1, 1'b0, 32'h00000123, 32'h00000FED};
        vecs[3]  = '{1'b1, 4'h4, 4'hC, 1'b0, 1'b1, 1'b0, 32'h00001234, 32'h0000FEDC};
        vecs[4]  = '{1'b1, 4'h5, 4'hB, 1'b0, 1'b1, 1'b0, 32'h00012345, 32'h000FEDCB};
        vecs[5]  = '{1'b1, 4'h6, 4'hA, 1'b0, 1'b1, 1'b0, 32'h00123456, 32'h00FEDCBA};
        vecs[6]  = '{1'b1, 4'h7, 4'h9, 1'b0, 1'b1, 1'b0, 32'h01234567, 32'h0FEDCBA9};
        vecs[7]  = '{1'b1, 4'h8, 4'h8, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'hFEDCBA98};
        vecs[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'hFEDCBA98};
        vecs[9]  = '{1'b1, 4'h9, 4'h9, 1'b1, 1'b1, 1'b0, 32'h12345678, 32'hFEDCBA98};
        vecs[10] = '{1'b1, 4'h1, 4'hF, 1'b0, 1'b1, 1'b0, 32'h23456781, 32'hEDCBA98F};
        vecs[11] = '{1'b1, 4'h2, 4'hE, 1'b0, 1'b1, 1'b0, 32'h34567812, 32'hDCBA98FE};
        vecs[12] = '{1'b1, 4'h3, 4'hD, 1'b0, 1'b1, 1'b0, 32'h45678123, 32'hCBA98FED};
        vecs[13] = '{1'b1, 4'h4, 4'hC, 1'b0, 1'b1, 1'b0, 32'h56781234, 32'hBA98FEDC};
        vecs[14] = '{1'b0, 4'h7, 4'h7, 1'b0, 1'b1, 1'b0, 32'h56781234, 32'hBA98FEDC};
        vecs[15] = '{1'b0, 4'h7, 4'h7, 1'b0, 1'b1, 1'b0, 32'h56781234, 32'hBA98FEDC};
        vecs[16] = '{1'b0, 4'h7, 4'h7, 1'b0, 1'b1, 1'b0, 32'h56781234, 32'hBA98FEDC};
        vecs[17] = '{1'b1, 4'h5, 4'hB, 1'b0, 1'b1, 1'b0, 32'h67812345, 32'hA98FEDCB};
        vecs[18] = '{1'b1, 4'h6, 4'hA, 1'b0, 1'b1, 1'b0, 32'h78123456, 32'h98FEDCBA};
        vecs[19] = '{1'b1, 4'h7, 4'h9, 1'b0, 1'b1, 1'b0, 32'h81234567, 32'h8FEDCBA9};
        vecs[20] = '{1'b1, 4'h8, 4'h8, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'hFEDCBA98};

        f0 = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
        f4 = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};

        rst = 1'b1;
        in_valid = 1'b0; in_digit = '0; out_ready = 1'b0; res_load = 1'b0; res_word = '0;
        in_valid2 = 1'b0; in_digit2 = '0; out_ready2 = 1'b0; res_load2 = 1'b0; res_word2 = '0;
        in_valid3 = 1'b0; in_digit3 = '0; out_ready3 = 1'b0; res_load3 = 1'b0; res_word3 = '0;

        @(negedge clk);
        @(negedge clk);
        reset_outputs_check("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst in_ready", in_ready, 1'b1);
        chk("post-rst out_valid", out_valid, 1'b0);

        // ---------------- table-driven loads ----------------
        for (int i = 0; i < 21; i++) begin
            in_valid  = vecs[i].vld;
            in_digit  = {vecs[i].d4, 4'h5, 4'hA, 4'h3, vecs[i].d0};
            out_ready = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i),  in_ready,           vecs[i].e_ird);
            chk($sformatf("vec%0d out_valid", i), out_valid,          vecs[i].e_ov);
            chk($sformatf("vec%0d word0", i),     word_of(int'(CH_PRIME)), vecs[i].e_w0);
            chk($sformatf("vec%0d word4", i),     word_of(int'(CH_K)),     vecs[i].e_w4);
        end
        in_valid = 1'b0;
        chk("word1", word_of(int'(CH_PX)), 32'h33333333);
        chk("word2", word_of(int'(CH_PY)), 32'hAAAAAAAA);
        chk("word3", word_of(int'(CH_A)),  32'h55555555);

        // ---------------- HOLD with out_ready low ----------------
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_digit = '1;
            @(negedge clk);
            chk($sformatf("hold%0d in_ready", i),  in_ready,  1'b0);
            chk($sformatf("hold%0d out_valid", i), out_valid, 1'b1);
            chk($sformatf("hold%0d word0", i),     word_of(0), 32'h12345678);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handoff out_valid", out_valid, 1'b0);
        chk("handoff in_ready", in_ready, 1'b1);
        chk("handoff word0 kept", word_of(0), 32'h12345678);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stray out_ready out_valid", out_valid, 1'b0);
        chk("stray out_ready in_ready", in_ready, 1'b1);

        // ---------------- serialiser ----------------
        sw = 32'hA5C30F96;
        res_word = sw; res_load = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("ser d%0d digit", k), res_digit, sw[35-4*k -: 4]);
            chk($sformatf("ser d%0d valid", k), res_valid, 1'b1);
            chk($sformatf("ser d%0d last", k),  res_last,  (k == 8));
            chk($sformatf("ser d%0d busy", k),  res_busy,  1'b1);
            if (k == 4) begin
                res_load = 1'b1; res_word = 32'hFFFFFFFF;
            end else if (k == 8) begin
                res_load = 1'b1; res_word = 32'h12345678;
            end else begin
                res_load = 1'b0;
            end
            @(negedge clk);
        end
        chk("ser end busy", res_busy, 1'b0);
        chk("ser end valid", res_valid, 1'b0);
        chk("ser end last", res_last, 1'b0);
        @(negedge clk);
        res_load = 1'b0;
        chk("ser reload valid", res_valid, 1'b1);
        chk("ser reload digit", res_digit, 4'h1);
        chk("ser reload busy", res_busy, 1'b1);
        repeat (8) @(negedge clk);
        chk("ser reload done", res_busy, 1'b0);

        // ---------------- reset mid-load and mid-serialisation ----------------
        in_valid = 1'b1; res_load = 1'b1; res_word = 32'hDEADBEEF;
        for (int k = 0; k < 5; k++) begin
            in_digit = {4'hC, 12'h777, f0[k]};
            @(negedge clk);
            res_load = 1'b0;
        end
        chk("pre-rst res_busy", res_busy, 1'b1);
        rst = 1'b1;
        #1;
        reset_outputs_check("mid-rst");
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid-rst release in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_digit = {f4[k], 12'h000, f0[k]};
            @(negedge clk);
            chk($sformatf("fresh beat%0d out_valid", k), out_valid, (k == 7));
        end
        in_valid = 1'b0;
        chk("fresh word0", word_of(0), 32'h9ABCDEF0);
        chk("fresh word1", word_of(1), 32'h0);
        chk("fresh word3", word_of(3), 32'h0);
        chk("fresh word4", word_of(4), 32'h01234567);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // ---------------- DIGIT_W=8, WORD_W=16, N_CH=2 ----------------
        in_valid2 = 1'b1; in_digit2 = {8'h12, 8'hAB};
        @(negedge clk);
        chk("p2 beat1 out_valid", out_valid2, 1'b0);
        in_digit2 = {8'h34, 8'hCD};
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("p2 out_valid", out_valid2, 1'b1);
        chk("p2 in_ready", in_ready2, 1'b0);
        chk("p2 words", out_words2, 32'h1234ABCD);
        res_load2 = 1'b1; res_word2 = 16'hBEEF;
        @(negedge clk);
        res_load2 = 1'b0;
        chk("p2 ser d1", res_digit2, 8'hBE);
        chk("p2 ser d1 last", res_last2, 1'b0);
        chk("p2 ser d1 valid", res_valid2, 1'b1);
        @(negedge clk);
        chk("p2 ser d2", res_digit2, 8'hEF);
        chk("p2 ser d2 last", res_last2, 1'b1);
        @(negedge clk);
        chk("p2 ser done busy", res_busy2, 1'b0);
        chk("p2 ser done valid", res_valid2, 1'b0);

        // ---------------- NDIG=1 ----------------
        in_valid3 = 1'b1; in_digit3 = 4'h7;
        @(negedge clk);
        in_valid3 = 1'b0;
        chk("p3 out_valid", out_valid3, 1'b1);
        chk("p3 in_ready", in_ready3, 1'b0);
        chk("p3 word", out_words3, 4'h7);
        out_ready3 = 1'b1;
        @(negedge clk);
        out_ready3 = 1'b0;
        chk("p3 handoff out_valid", out_valid3, 1'b0);
        res_load3 = 1'b1; res_word3 = 4'h9;
        @(negedge clk);
        res_load3 = 1'b0;
        chk("p3 ser digit", res_digit3, 4'h9);
        chk("p3 ser last", res_last3, 1'b1);
        chk("p3 ser busy", res_busy3, 1'b1);
        @(negedge clk);
        chk("p3 ser done busy", res_busy3, 1'b0);
        chk("p3 ser done valid", res_valid3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ecc_operand_loader
`default_nettype wire

// File: doc/ecc_operand_loader.md
# ecc_operand_loader

Parametrised digit-serial I/O front end for the ECC scalar-multiplication core. It assembles N_CH operand words (prime, Px, Py, a, k in the default configuration) from a narrow digit bus and presents them to Control/GFAU through a valid/ready handshake. It also serialises the WORD_W-bit result back onto a DIGIT_W-bit output bus. It sits between the chip pins and the arithmetic core.

## Interface
- DIGIT_W, 4, digit bus width per channel in bits
- WORD_W, 32, operand/result word width; must be an integer multiple of DIGIT_W
- N_CH, 5, number of operand channels loaded in parallel
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input digit beat present on in_digit
- in_digit  in  N_CH*DIGIT_W  one digit per channel; channel c occupies bits [c*DIGIT_W +: DIGIT_W]
- in_ready  out  1  loader accepts a beat this cycle
- out_valid  out  1  all N_CH words complete and stable
- out_ready  in  1  core has taken the operands
- out_words  out  N_CH*WORD_W  assembled words; channel c occupies bits [c*WORD_W +: WORD_W]
- res_load  in  1  capture res_word and start serialising it
- res_word  in  WORD_W  result from the core
- res_busy  out  1  serialiser active
- res_valid  out  1  res_digit is valid this cycle
- res_digit  out  DIGIT_W  result digit, most significant digit first
- res_last  out  1  marks the final digit of a result

## Operation
- NDIG = WORD_W/DIGIT_W. The digit counter is $clog2(NDIG+1) bits wide.
- Input FSM states: IDLE, LOAD, HOLD.
  - IDLE: in_ready=1.
  - LOAD: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- A beat is in_valid && in_ready. On each beat, every channel word shifts left by DIGIT_W and the new digit is inserted in the LSBs. The first digit of a word is therefore its MSD.
- The first beat is captured in the cycle in_valid first rises. No beat is dropped.
- Transitions:
  - IDLE --beat--> LOAD with cnt=1, or directly to HOLD if NDIG==1.
  - LOAD --beat with cnt==NDIG-1--> HOLD, cnt cleared.
  - LOAD with in_valid=0: stall. Words and cnt hold. Gaps are unlimited.
  - HOLD --out_ready--> IDLE.
- out_words holds its value after the handoff until the next first beat.
- Entering IDLE from HOLD does not clear the words. A new load fully overwrites them after NDIG beats.
- Serialiser (independent FSM):
  - res_load while !res_busy captures res_word, sets res_busy=1, and clears the index.
  - Each following cycle outputs digit res_word[WORD_W-1-i*DIGIT_W -: DIGIT_W] with res_valid=1.
  - res_last=1 when i==NDIG-1. res_busy falls after the last digit.
  - There is no backpressure on this path.
  - res_load while res_busy is ignored. The in-flight result is not corrupted.
- Both FSMs run concurrently. Simultaneous input beats and serialiser activity are legal.

## Timing
- Reset values: in_ready=0 while rst is asserted, then 1 in IDLE. out_valid=0, out_words=0, res_busy=0, res_valid=0, res_digit=0, res_last=0. cnt=0, both FSMs idle.
- Load latency: with back-to-back beats, out_valid rises the cycle after the NDIG-th beat.
- The handshake completes on the edge where out_valid && out_ready are both high. out_valid is 0 the next cycle.
- out_ready while !out_valid has no effect.
- Minimum load period is NDIG+1 cycles per operand set.
- Serialiser: res_load at edge t gives the first res_valid in cycle t+1 and the last digit in cycle t+NDIG. res_busy=1 from t+1 through t+NDIG.
  - A new res_load at the edge that ends the last digit is ignored, because res_busy is still 1.
  - A res_load one cycle later is accepted.
- All outputs are registered. There is no combinational path from in_valid, out_ready or res_load to any output.
- rst asserted mid-load or mid-serialisation: immediately return to reset values. A partial word is discarded.

## Structure
- The shared ecc_pkg holds:
  - The default DIGIT_W/WORD_W/N_CH constants.
  - The channel index enum: CH_PRIME=0, CH_PX, CH_PY, CH_A, CH_K.
  - The loader state enum.
- One sub-module, digit_serializer (the result path), is parametrised by DIGIT_W and WORD_W.
- The top-level Top instantiates ecc_operand_loader in place of its inline shift registers.

## Test plan
- Reset, then 8 back-to-back beats with channel 0 digits 1,2,…,8 and channel 4 digits F,E,…,8 → out_valid in cycle 9; word0=0x12345678, word4=0xFEDCBA98.
- Same load with in_valid dropped for 3 cycles after beat 4 → identical words; out_valid delayed by exactly 3 cycles.
- out_ready held low for 10 cycles in HOLD → in_ready=0 and words stable throughout; out_ready=1 → out_valid=0 the next cycle, in_ready=1.
- res_load with res_word=0xA5C3_0F96 → digits A,5,C,3,0,F,9,6 on cycles t+1..t+8, res_last only on 6; a res_load at t+4 is ignored.
- rst pulsed after beat 5 of a load → all outputs at reset values; a fresh 8-beat load yields correct words with no residue.
- Parameter sweep: DIGIT_W=8, WORD_W=16, N_CH=2 → 2-beat load and 2-digit serialisation are correct; NDIG=1 configuration reaches HOLD after one beat.
